// File: rtl/phy_tx_sched_pkg.sv
// Shared definitions for the phy_TX transmit scheduler: state encoding,
// sync pattern and the phy_TX word width.
package phy_tx_sched_pkg;

  localparam int          PHY_WORD_W   = 32;
  localparam logic [31:0] COM_WORD_DEF = 32'hBCBCBCBC;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SYNC = 2'd1,
    ST_IDLE = 2'd2,
    ST_XFER = 2'd3
  } state_t;

endpackage

// File: rtl/phy_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester after
// the last grantee, checking the last grantee itself only at the end.
module phy_tx_sched_rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    next_grant,
  output logic             any_valid
);

  always_comb begin
    next_grant = last_grant;
    any_valid  = |req_valid;
    // Descending scan so the nearest successor is the final (winning) assignment
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant) + k) % N_REQ]) begin
        next_grant = GW'((int'(last_grant) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/phy_tx_sched.sv
// Transmit scheduler in front of phy_TX: link bring-up with COM words, then
// round-robin bursts from N_REQ word sources onto the single phy_TX input.
module phy_tx_sched
  import phy_tx_sched_pkg::*;
#(
  parameter  int                N_REQ      = 2,
  parameter  int                DATA_W     = PHY_WORD_W,
  parameter  int                INIT_WORDS = 4,
  parameter  int                MAX_BURST  = 4,
  parameter  logic [DATA_W-1:0] COM_WORD   = DATA_W'(COM_WORD_DEF),
  localparam int                GW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_f,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       data_input,
  output logic                    valid,
  output logic                    active,
  output logic [GW-1:0]           grant,
  output logic [1:0]              state
);

  localparam int             BW         = $clog2(MAX_BURST) + 1;
  localparam int             SW         = $clog2(INIT_WORDS) + 1;
  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [SW-1:0]  SYNC_LAST  = SW'(INIT_WORDS - 1);
  localparam logic [GW-1:0]  GRANT_RST  = GW'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [BW-1:0]      burst_cnt, burst_d;
  logic [SW-1:0]      sync_cnt, sync_d;
  logic [DATA_W-1:0]  data_d;
  logic               valid_d;
  logic [GW-1:0]      rr_next;
  logic               any_valid;
  logic [DATA_W-1:0]  sel_word;

  phy_tx_sched_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_valid  (req_valid),
    .last_grant (grant_q),
    .next_grant (rr_next),
    .any_valid  (any_valid)
  );

  assign sel_word = req_data[int'(grant_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    burst_d   = burst_cnt;
    sync_d    = sync_cnt;
    data_d    = '0;
    valid_d   = 1'b0;
    req_ready = '0;
    if (state_q != ST_OFF && !enable) begin
      // Link drop wins over everything: nothing is accepted this cycle
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (enable) begin
            state_d = ST_SYNC;
            sync_d  = '0;
          end
        end
        ST_SYNC: begin
          data_d = COM_WORD;
          sync_d = sync_cnt + 1'b1;
          if (sync_cnt == SYNC_LAST) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (any_valid) begin
            grant_d = rr_next;
            burst_d = '0;
            state_d = ST_XFER;
          end
        end
        ST_XFER: begin
          req_ready[grant_q] = 1'b1;
          if (req_valid[grant_q]) begin
            data_d  = sel_word;
            valid_d = 1'b1;
            burst_d = burst_cnt + 1'b1;
          end
          // Re-arbitrate at burst end or on a bubble; new grant serves next cycle
          if (!req_valid[grant_q] || burst_cnt == BURST_LAST) begin
            if (any_valid) begin
              grant_d = rr_next;
              burst_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OFF;
      grant_q    <= GRANT_RST;
      burst_cnt  <= '0;
      sync_cnt   <= '0;
      data_input <= '0;
      valid      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      burst_cnt  <= burst_d;
      sync_cnt   <= sync_d;
      data_input <= data_d;
      valid      <= valid_d;
    end
  end

  assign active = (state_q != ST_OFF);
  assign grant  = grant_q;
  assign state  = state_q;

endmodule

// File: tb/tb_phy_tx_sched.sv
// Directed bench for phy_tx_sched: bring-up, single/dual requester bursts,
// link drop and asynchronous reset during a transfer.
module tb_phy_tx_sched;

  localparam int          N_REQ  = 2;
  localparam int          DATA_W = 32;
  localparam logic [31:0] COM    = 32'hBCBCBCBC;
  localparam logic [31:0] A_BASE = 32'hA000_0000;
  localparam logic [31:0] B_BASE = 32'hB100_0000;

  logic                    clk_f = 1'b0;
  logic                    reset;
  logic                    enable;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       data_input;
  logic                    valid;
  logic                    active;
  logic [0:0]              grant;
  logic [1:0]              state;

  int ntests = 0;
  int nfail  = 0;
  int cnt0 = 0, cnt1 = 0, lim0 = 0, lim1 = 0;

  phy_tx_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk_f      (clk_f),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .data_input (data_input),
    .valid      (valid),
    .active     (active),
    .grant      (grant),
    .state      (state)
  );

  always #5 clk_f = ~clk_f;

  task automatic update_src();
    req_valid[0]      = (cnt0 < lim0);
    req_valid[1]      = (cnt1 < lim1);
    req_data[31:0]    = A_BASE + 32'(cnt0);
    req_data[63:32]   = B_BASE + 32'(cnt1);
  endtask

  // One clock: requesters consume on handshake, outputs sampled 2 units after the edge
  task automatic tick();
    logic [N_REQ-1:0] acc;
    acc = req_valid & req_ready;
    @(posedge clk_f);
    #1;
    if (acc[0]) cnt0++;
    if (acc[1]) cnt1++;
    update_src();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; lim0 = 0; lim1 = 0; update_src();
    repeat (2) @(posedge clk_f);
    #2;
    ntests++; if (state !== 2'd0) begin nfail++; $display("FAIL reset_state got %0d want 0", state); end
    ntests++; if (data_input !== 32'h0) begin nfail++; $display("FAIL reset_data got %h want 0", data_input); end
    ntests++; if (valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", valid); end
    ntests++; if (active !== 1'b0) begin nfail++; $display("FAIL reset_active got %b want 0", active); end
    ntests++; if (grant !== 1'b1) begin nfail++; $display("FAIL reset_grant got %0d want 1", grant); end
    reset = 1'b0;
    tick();
    ntests++; if (req_ready !== 2'b00 || state !== 2'd0) begin nfail++; $display("FAIL reset_idle got ready=%b state=%0d want 00/0", req_ready, state); end
  endtask

  task automatic test_bringup();
    enable = 1'b1;
    tick();
    ntests++; if (active !== 1'b1 || state !== 2'd1) begin nfail++; $display("FAIL bringup_active got active=%b state=%0d want 1/1", active, state); end
    for (int i = 0; i < 4; i++) begin
      tick();
      ntests++; if (data_input !== COM || valid !== 1'b0) begin nfail++; $display("FAIL bringup_com[%0d] got %h/%b want %h/0", i, data_input, valid, COM); end
    end
    ntests++; if (state !== 2'd2) begin nfail++; $display("FAIL bringup_idle_state got %0d want 2", state); end
    tick();
    ntests++; if (data_input !== 32'h0 || valid !== 1'b0 || state !== 2'd2) begin nfail++; $display("FAIL bringup_after got %h/%b/%0d want 0/0/2", data_input, valid, state); end
  endtask

  task automatic test_single_req0();
    cnt0 = 0; lim0 = 6; update_src(); #1;
    tick();
    ntests++; if (state !== 2'd3 || grant !== 1'b0 || req_ready !== 2'b01) begin nfail++; $display("FAIL single_start got st=%0d g=%0d rdy=%b want 3/0/01", state, grant, req_ready); end
    for (int k = 0; k < 6; k++) begin
      ntests++; if (grant !== 1'b0) begin nfail++; $display("FAIL single_grant[%0d] got %0d want 0", k, grant); end
      tick();
      ntests++; if (valid !== 1'b1 || data_input !== A_BASE + 32'(k)) begin nfail++; $display("FAIL single_word[%0d] got %h/%b want %h/1", k, data_input, valid, A_BASE + 32'(k)); end
    end
    tick();
    ntests++; if (valid !== 1'b0) begin nfail++; $display("FAIL single_end_valid got %b want 0", valid); end
    ntests++; if (state !== 2'd2) begin nfail++; $display("FAIL single_end_state got %0d want 2", state); end
  endtask

  task automatic test_only_req1();
    cnt1 = 0; lim1 = 2; update_src(); #1;
    tick();
    ntests++; if (grant !== 1'b1 || req_ready !== 2'b10) begin nfail++; $display("FAIL req1_grant got g=%0d rdy=%b want 1/10", grant, req_ready); end
    tick();
    ntests++; if (valid !== 1'b1 || data_input !== B_BASE) begin nfail++; $display("FAIL req1_word0 got %h/%b want %h/1", data_input, valid, B_BASE); end
    tick();
    ntests++; if (valid !== 1'b1 || data_input !== B_BASE + 32'd1) begin nfail++; $display("FAIL req1_word1 got %h/%b want %h/1", data_input, valid, B_BASE + 32'd1); end
    tick();
    tick();
    ntests++; if (state !== 2'd2 || valid !== 1'b0) begin nfail++; $display("FAIL req1_end got st=%0d v=%b want 2/0", state, valid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_word [12];
    logic        exp_g    [12];
    for (int k = 0; k < 4; k++) begin
      exp_word[k]     = A_BASE + 32'(k);     exp_g[k]     = 1'b0;
      exp_word[k + 4] = B_BASE + 32'(k);     exp_g[k + 4] = 1'b1;
      exp_word[k + 8] = A_BASE + 32'(k + 4); exp_g[k + 8] = 1'b0;
    end
    cnt0 = 0; cnt1 = 0; lim0 = 100; lim1 = 100; update_src(); #1;
    tick();
    for (int k = 0; k < 12; k++) begin
      ntests++; if (grant !== exp_g[k] || req_ready !== (exp_g[k] ? 2'b10 : 2'b01)) begin nfail++; $display("FAIL rr_grant[%0d] got g=%0d rdy=%b want %0d", k, grant, req_ready, exp_g[k]); end
      tick();
      ntests++; if (valid !== 1'b1 || data_input !== exp_word[k]) begin nfail++; $display("FAIL rr_word[%0d] got %h/%b want %h/1", k, data_input, valid, exp_word[k]); end
    end
    lim0 = 0; lim1 = 0; cnt0 = 0; cnt1 = 0; update_src(); #1;
    tick();
    tick();
    ntests++; if (state !== 2'd2 || grant !== 1'b1) begin nfail++; $display("FAIL rr_end got st=%0d g=%0d want 2/1", state, grant); end
  endtask

  task automatic test_enable_drop();
    cnt0 = 0; lim0 = 4; update_src(); #1;
    tick();
    ntests++; if (req_ready !== 2'b01) begin nfail++; $display("FAIL drop_ready0 got %b want 01", req_ready); end
    tick();
    enable = 1'b0; #1;
    ntests++; if (req_ready !== 2'b00) begin nfail++; $display("FAIL drop_ready got %b want 00", req_ready); end
    ntests++; if (valid !== 1'b1 || data_input !== A_BASE) begin nfail++; $display("FAIL drop_prev_word got %h/%b want %h/1", data_input, valid, A_BASE); end
    tick();
    ntests++; if (state !== 2'd0 || active !== 1'b0) begin nfail++; $display("FAIL drop_off got st=%0d act=%b want 0/0", state, active); end
    ntests++; if (valid !== 1'b0 || data_input !== 32'h0) begin nfail++; $display("FAIL drop_valid got %h/%b want 0/0", data_input, valid); end
    tick();
    ntests++; if (state !== 2'd0 || req_ready !== 2'b00) begin nfail++; $display("FAIL drop_hold got st=%0d rdy=%b want 0/00", state, req_ready); end
  endtask

  task automatic test_reset_mid();
    lim0 = 100; update_src();
    enable = 1'b1;
    repeat (5) tick();
    tick();
    tick();
    ntests++; if (valid !== 1'b1 || data_input !== A_BASE + 32'd1) begin nfail++; $display("FAIL rst_pre_word got %h/%b want %h/1", data_input, valid, A_BASE + 32'd1); end
    tick();
    #2; reset = 1'b1; #1;
    ntests++; if (state !== 2'd0 || valid !== 1'b0 || data_input !== 32'h0 || active !== 1'b0) begin nfail++; $display("FAIL rst_async got st=%0d v=%b d=%h act=%b want all 0", state, valid, data_input, active); end
    ntests++; if (req_ready !== 2'b00 || grant !== 1'b1) begin nfail++; $display("FAIL rst_async_ctl got rdy=%b g=%0d want 00/1", req_ready, grant); end
    tick();
    reset = 1'b0;
    tick();
    ntests++; if (state !== 2'd1) begin nfail++; $display("FAIL rst_resync_state got %0d want 1", state); end
    for (int i = 0; i < 4; i++) begin
      tick();
      ntests++; if (data_input !== COM || valid !== 1'b0) begin nfail++; $display("FAIL rst_com[%0d] got %h/%b want %h/0", i, data_input, valid, COM); end
    end
    tick();
    tick();
    ntests++; if (valid !== 1'b1 || data_input !== A_BASE + 32'd3) begin nfail++; $display("FAIL rst_first_word got %h/%b want %h/1", data_input, valid, A_BASE + 32'd3); end
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_bringup();
    test_single_req0();
    test_only_req1();
    test_round_robin();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
